// File: rtl/booth_seq_mult_pkg.sv
// booth_seq_mult_pkg
//   Shared types and constants for the sequential radix-4 Booth multiplier.
//   - DEFAULT_W     : default operand width (bits, signed two's complement)
//   - state_t       : controller states IDLE / BUSY / DONE
//   - booth_digit_t : one-hot recoded Booth digit (neg, x1, x2)
//   - booth_encode  : maps a 3-bit overlapping multiplier window to a digit
package booth_seq_mult_pkg;

  localparam int DEFAULT_W = 16;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  // x1 and x2 are mutually exclusive; both low means a zero digit.
  typedef struct packed {
    logic neg;
    logic x1;
    logic x2;
  } booth_digit_t;

  // Window is {b[2k+1], b[2k], b[2k-1]}.
  function automatic booth_digit_t booth_encode(input logic [2:0] bits);
    booth_digit_t d;
    d = '0;
    case (bits)
      3'b001, 3'b010: d.x1 = 1'b1;
      3'b011:         d.x2 = 1'b1;
      3'b100:         begin d.neg = 1'b1; d.x2 = 1'b1; end
      3'b101, 3'b110: begin d.neg = 1'b1; d.x1 = 1'b1; end
      default:        d = '0;  // 000 and 111 are both zero digits
    endcase
    return d;
  endfunction

endpackage

// File: rtl/booth_seq_mult_digit_row.sv
// booth_digit_row
//   Combinational partial-product generator for one radix-4 Booth digit.
//   Ports:
//     digit [2:0]  : overlapping multiplier window {b[2k+1], b[2k], b[2k-1]}
//     a     [W-1:0]: signed multiplicand
//     pp    [W+1:0]: sign-extended magnitude (a or 2a), one's-complemented
//                    when the digit is negative
//     neg          : carry-in that completes the two's-complement negation
module booth_digit_row
  import booth_seq_mult_pkg::*;
#(
  parameter int W = DEFAULT_W
) (
  input  logic [2:0]   digit,
  input  logic [W-1:0] a,
  output logic [W+1:0] pp,
  output logic         neg
);

  booth_digit_t enc;
  logic [W+1:0] a_ext;
  logic [W+1:0] mag;

  assign enc   = booth_encode(digit);
  // Two guard bits keep 2*a and -(2*a) representable for every a.
  assign a_ext = {{2{a[W-1]}}, a};

  always_comb begin
    mag = '0;
    if (enc.x2) begin
      mag = a_ext << 1;
    end else if (enc.x1) begin
      mag = a_ext;
    end
  end

  // The +1 of the negation is left to the accumulator adder as a carry-in.
  assign pp  = enc.neg ? ~mag : mag;
  assign neg = enc.neg;

endmodule

// File: rtl/booth_seq_mult.sv
// booth_seq_mult
//   Sequential signed multiplier, one radix-4 Booth digit per clock.
//   A product takes W/2 cycles in BUSY, then is held in DONE until taken.
//   Ports:
//     clk, rst            : clock, asynchronous active-high reset
//     in_valid / in_ready : operand handshake (ready only in IDLE)
//     a, b                : signed multiplicand / multiplier
//     out_valid/out_ready : result handshake (valid only in DONE)
//     product [2W-1:0]    : signed a*b, forced to 0 while out_valid is low
//     busy                : high while digits are being processed
module booth_seq_mult
  import booth_seq_mult_pkg::*;
#(
  parameter int W = DEFAULT_W
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic [W-1:0]   a,
  input  logic [W-1:0]   b,
  output logic           out_valid,
  input  logic           out_ready,
  output logic [2*W-1:0] product,
  output logic           busy
);

  localparam int NDIG  = W / 2;
  localparam int CNT_W = (NDIG > 1) ? $clog2(NDIG) : 1;
  localparam logic [CNT_W-1:0] LAST_DIGIT = CNT_W'(NDIG - 1);

  state_t           state_reg, state_next;
  logic [W-1:0]     a_reg, b_reg;
  logic [CNT_W-1:0] cnt_reg;
  logic [2*W-1:0]   acc_reg;

  logic [W:0]       b_ext;
  logic [2:0]       digit;
  logic [W+1:0]     pp;
  logic             pp_neg;
  logic [2*W-1:0]   pp_ext;
  logic [2*W-1:0]   addend;
  logic [2*W-1:0]   acc_next;
  logic             last_digit;

  // Appending the implicit b[-1]=0 lets digit k be read at bit offset 2k.
  assign b_ext = {b_reg, 1'b0};
  assign digit = 3'(b_ext >> {cnt_reg, 1'b0});

  booth_digit_row #(.W(W)) u_row (
    .digit (digit),
    .a     (a_reg),
    .pp    (pp),
    .neg   (pp_neg)
  );

  // Sign-extend, complete the negation, then weight by 4^k. Working modulo
  // 2^(2W) is exact because the final product always fits in 2W bits.
  assign pp_ext     = {{(W-2){pp[W+1]}}, pp};
  assign addend     = (pp_ext + {{(2*W-1){1'b0}}, pp_neg}) << {cnt_reg, 1'b0};
  assign acc_next   = acc_reg + addend;
  assign last_digit = (cnt_reg == LAST_DIGIT);

  always_comb begin
    state_next = state_reg;
    in_ready   = 1'b0;
    out_valid  = 1'b0;
    busy       = 1'b0;
    case (state_reg)
      ST_IDLE: begin
        in_ready = 1'b1;
        if (in_valid) state_next = ST_BUSY;
      end
      ST_BUSY: begin
        busy = 1'b1;
        if (last_digit) state_next = ST_DONE;
      end
      ST_DONE: begin
        out_valid = 1'b1;
        if (out_ready) state_next = ST_IDLE;
      end
      default: state_next = ST_IDLE;  // unused encoding falls back to IDLE
    endcase
  end

  assign product = out_valid ? acc_reg : '0;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg <= ST_IDLE;
      a_reg     <= '0;
      b_reg     <= '0;
      cnt_reg   <= '0;
      acc_reg   <= '0;
    end else begin
      state_reg <= state_next;
      case (state_reg)
        ST_IDLE: begin
          if (in_valid) begin
            a_reg   <= a;
            b_reg   <= b;
            cnt_reg <= '0;
            acc_reg <= '0;
          end
        end
        ST_BUSY: begin
          acc_reg <= acc_next;
          // Counter parks on the last digit instead of wrapping.
          if (!last_digit) cnt_reg <= cnt_reg + 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: doc/booth_seq_mult.md
BOOTH_SEQ_MULT -- requirements
Module: booth_seq_mult

Interface
REQ-001 Parameter W, default 16: operand width in bits, signed two's complement; SHALL be even and >= 4.
REQ-002 clk  input  1  single clock; all state updates on the rising edge.
REQ-003 rst  input  1  reset, asynchronous and active-high.
REQ-004 in_valid  input  1  operand pair present on a/b.
REQ-005 in_ready  output  1  block can accept an operand pair.
REQ-006 a  input  W  signed multiplicand.
REQ-007 b  input  W  signed multiplier, radix-4 Booth recoded.
REQ-008 out_valid  output  1  product is valid.
REQ-009 out_ready  input  1  consumer accepts the product.
REQ-010 product  output  2W  signed product a*b.
REQ-011 busy  output  1  high while a multiplication is in progress (BUSY state).

Function
REQ-012 The FSM SHALL have exactly the states IDLE, BUSY and DONE.
REQ-013 in_ready SHALL equal (state==IDLE); out_valid SHALL equal (state==DONE); busy SHALL equal (state==BUSY).
REQ-014 The input handshake SHALL occur on an edge with in_valid&&in_ready: a and b are captured, digit counter is cleared to 0, accumulator is cleared to 0, and the state becomes BUSY.
REQ-015 In BUSY, each edge SHALL process one Booth digit k (0..W/2-1), formed from bits b[2k+1], b[2k], b[2k-1], with b[-1]=0.
REQ-016 Digit recoding SHALL be: 000/111->0, 001/010->+1, 011->+2, 100->-2, 101/110->-1.
REQ-017 Each partial product SHALL be digit*a, sign-extended to W+2 bits: magnitude first (a or a<<1), then negated as one's complement plus a neg carry-in bit.
REQ-018 The accumulator SHALL add each partial product weighted by 4^k, with full 2W-bit signed arithmetic and no overflow loss.
REQ-019 After digit W/2-1 is processed, the state SHALL become DONE; out_valid therefore rises exactly W/2 edges after the accepting edge (8 for W=16).
REQ-020 In DONE, product SHALL hold the exact signed value a*b stable until the edge where out_ready is high, at which point the state returns to IDLE.
REQ-021 product SHALL read 0 whenever out_valid is low.
REQ-022 There is no bypass: in_valid asserted during DONE, including the cycle where out_ready is high, SHALL NOT be accepted until the following IDLE cycle.
REQ-023 In BUSY, in_valid and out_ready SHALL be ignored; captured operands SHALL NOT change.
REQ-024 The digit counter SHALL saturate and not wrap; no state other than IDLE/BUSY/DONE SHALL be reachable, and an illegal encoding SHALL recover to IDLE.

Reset
REQ-025 On rst high, at any time including mid-BUSY or in DONE, the block SHALL immediately enter IDLE with in_ready=1, out_valid=0, busy=0 and product=0.
REQ-026 Accumulator, digit counter and captured operands SHALL clear to 0; an in-flight result SHALL be discarded.
REQ-027 The first edge after rst deasserts SHALL be able to accept a new operand pair.

Structure
REQ-028 A shared package SHALL hold the FSM state enum, the Booth digit encoding type (neg, x1, x2 one-hot) and the default operand width constant.
REQ-029 One sub-module SHALL be instantiated: booth_digit_row. It is combinational and maps a 3-bit digit plus a to a (W+2)-bit partial product and a neg bit.
REQ-030 FSM, counter and accumulator SHALL live in booth_seq_mult.

Verification
REQ-031 a=3, b=5, out_ready=1 -> out_valid rises 8 edges after accept, product=0x0000000F, in_ready returns the next cycle.
REQ-032 a=-32768, b=-32768 -> product=0x40000000; a=32767, b=-32768 -> product=0xC0008000; a=-1, b=-1 -> product=0x00000001.
REQ-033 a=-7, b=12 with out_ready held low 5 cycles -> product=0xFFFFFFAC held stable, in_ready=0 throughout; returns to IDLE on the edge where out_ready rises.
REQ-034 rst pulsed during the 4th BUSY cycle -> in_ready=1, out_valid=0, product=0 immediately; a new pair a=2, b=2 yields product=4 with no residue.
REQ-035 in_valid held high continuously with out_ready=1 -> back-to-back products appear every 10 cycles (accept, 8 BUSY, DONE), with no operand dropped or duplicated.
REQ-036 10,000 random signed (a,b) pairs with random out_ready stalls -> every product matches a reference a*b.
